coreahblsram_sram_arbiter: RTL and testbench



---
 rtl/coreahblsram_pkg.sv | 20 ++
 rtl/coreahblsram_starve_cnt.sv | 46 ++++
 rtl/coreahblsram_sram_arbiter.sv | 157 +++++++++++++++
 tb/tb_coreahblsram_sram_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coreahblsram_pkg.sv
// ---------------------------------------------------------------------------
// coreahblsram_pkg
// Shared constants for the CoreAHBLSRAM SRAM arbiter slice: SRAM data and
// byte-enable widths, the starvation counter width and the arbiter state
// encodings.
// ---------------------------------------------------------------------------
package coreahblsram_pkg;

    localparam int SRAM_DWIDTH  = 40;
    localparam int SRAM_BEWIDTH = 4;
    localparam int CNT_WIDTH    = 8;

    // Arbiter states. These are plain constants so older tools that reject
    // package enums can still elaborate the design.
    typedef logic [1:0] arb_state_t;
    localparam arb_state_t ST_PRI = 2'd0;   // AHB has fixed priority
    localparam arb_state_t ST_RSV = 2'd1;   // BUSY raised, last AHB cycle allowed
    localparam arb_state_t ST_SEC = 2'd2;   // window reserved for the secondary

endpackage

// File: rtl/coreahblsram_starve_cnt.sv
// ---------------------------------------------------------------------------
// coreahblsram_starve_cnt
// Saturating wait counter for the secondary requester. Counts cycles in which
// the secondary request is pending but not granted and clears as soon as the
// request is granted or withdrawn.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   waiting    in   secondary request pending and not granted this cycle
//   limit_hit  out  counter has reached STARVE_LIMIT (registered value)
// ---------------------------------------------------------------------------
module coreahblsram_starve_cnt
    import coreahblsram_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic waiting,
    output logic limit_hit
);

    localparam logic [CNT_WIDTH-1:0] LIMIT_C = CNT_WIDTH'(STARVE_LIMIT);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = '0;
        if (waiting) begin
            cnt_d = (cnt_q == LIMIT_C) ? cnt_q : cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign limit_hit = (cnt_q == LIMIT_C);

endmodule

// File: rtl/coreahblsram_sram_arbiter.sv
// ---------------------------------------------------------------------------
// coreahblsram_sram_arbiter
// Shares the 40-bit SRAM between the AHB-Lite SRAM interface (primary, fixed
// priority, zero added latency) and one secondary requester. A starvation
// counter forces a one-access window for the secondary; the AHB side is told
// to hold off through the registered BUSY output.
//
// Ports:
//   HCLK, HRESETN              clock / async active-low reset
//   ahb_write/read/addr/wdata/byteen, ahb_rdata   AHB-side SRAM port
//   BUSY                       registered: AHB side must not issue
//   sec_req/write/addr/wdata/byteen               secondary request
//   sec_gnt                    combinational grant (access this cycle)
//   sec_rvalid, sec_rdata      secondary read return (one cycle after grant)
//   mem_wen/ren/addr/wdata, mem_rdata             SRAM macro port
//   prot_err                   sticky: AHB access attempted in the SEC window
// ---------------------------------------------------------------------------
module coreahblsram_sram_arbiter
    import coreahblsram_pkg::*;
#(
    parameter int MEM_AWIDTH   = 19,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                    HCLK,
    input  logic                    HRESETN,
    input  logic                    ahb_write,
    input  logic                    ahb_read,
    input  logic [MEM_AWIDTH-1:0]   ahb_addr,
    input  logic [SRAM_DWIDTH-1:0]  ahb_wdata,
    input  logic [SRAM_BEWIDTH-1:0] ahb_byteen,
    output logic [SRAM_DWIDTH-1:0]  ahb_rdata,
    output logic                    BUSY,
    input  logic                    sec_req,
    input  logic                    sec_write,
    input  logic [MEM_AWIDTH-1:0]   sec_addr,
    input  logic [SRAM_DWIDTH-1:0]  sec_wdata,
    input  logic [SRAM_BEWIDTH-1:0] sec_byteen,
    output logic                    sec_gnt,
    output logic                    sec_rvalid,
    output logic [SRAM_DWIDTH-1:0]  sec_rdata,
    output logic [SRAM_BEWIDTH-1:0] mem_wen,
    output logic                    mem_ren,
    output logic [MEM_AWIDTH-1:0]   mem_addr,
    output logic [SRAM_DWIDTH-1:0]  mem_wdata,
    input  logic [SRAM_DWIDTH-1:0]  mem_rdata,
    output logic                    prot_err
);

    arb_state_t state_q, state_d;
    logic       busy_q, busy_d;
    logic       rd_sec_q, rd_sec_d;
    logic       prot_err_q, prot_err_d;
    logic [SRAM_DWIDTH-1:0] sec_rdata_q, sec_rdata_d;
    logic [MEM_AWIDTH-1:0]  mem_addr_q, mem_addr_d;
    logic [SRAM_DWIDTH-1:0] mem_wdata_q, mem_wdata_d;

    logic ahb_act;
    logic ahb_own;
    logic limit_hit;

    assign ahb_act = ahb_read | ahb_write;
    // In SEC the AHB strobes are ignored; in PRI and RSV the AHB side wins.
    assign ahb_own = ahb_act & (state_q != ST_SEC);
    assign sec_gnt = sec_req & ~ahb_own;

    coreahblsram_starve_cnt #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_cnt (
        .clk       (HCLK),
        .rst_n     (HRESETN),
        .waiting   (sec_req & ~sec_gnt),
        .limit_hit (limit_hit)
    );

    // SRAM port mux. Address and write data hold their last values when
    // nobody is accessing so the macro inputs do not toggle needlessly.
    always_comb begin
        mem_wen     = '0;
        mem_ren     = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (ahb_own) begin
            // Both strobes high are passed through as-is.
            mem_wen     = ahb_byteen & {SRAM_BEWIDTH{ahb_write}};
            mem_ren     = ahb_read;
            mem_addr_d  = ahb_addr;
            mem_wdata_d = ahb_wdata;
        end else if (sec_gnt) begin
            mem_wen     = sec_byteen & {SRAM_BEWIDTH{sec_write}};
            mem_ren     = ~sec_write;
            mem_addr_d  = sec_addr;
            mem_wdata_d = sec_wdata;
        end
    end

    assign mem_addr  = mem_addr_d;
    assign mem_wdata = mem_wdata_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_PRI: begin
                // A request served on the very cycle the limit is reached
                // has no need for a reserved window.
                if (limit_hit && sec_req && !sec_gnt) begin
                    state_d = ST_RSV;
                end
            end
            ST_RSV: begin
                state_d = sec_gnt ? ST_PRI : ST_SEC;
            end
            ST_SEC: begin
                // Grant equals request here, so the window always closes
                // after one cycle: either the access happened or the
                // requester withdrew.
                state_d = ST_PRI;
            end
            default: begin
                state_d = ST_PRI;
            end
        endcase
    end

    always_comb begin
        busy_d      = (state_d != ST_PRI);
        rd_sec_d    = sec_gnt & ~sec_write;
        prot_err_d  = prot_err_q | ((state_q == ST_SEC) & ahb_act);
        sec_rdata_d = rd_sec_q ? mem_rdata : sec_rdata_q;
    end

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            state_q     <= ST_PRI;
            busy_q      <= 1'b0;
            rd_sec_q    <= 1'b0;
            prot_err_q  <= 1'b0;
            sec_rdata_q <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            rd_sec_q    <= rd_sec_d;
            prot_err_q  <= prot_err_d;
            sec_rdata_q <= sec_rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign BUSY       = busy_q;
    assign sec_rvalid = rd_sec_q;
    assign sec_rdata  = sec_rdata_d;
    assign prot_err   = prot_err_q;
    assign ahb_rdata  = mem_rdata;

endmodule

// File: tb/tb_coreahblsram_sram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_coreahblsram_sram_arbiter
// Directed scenarios followed by randomized traffic against a behavioural
// model of the arbiter and a simple SRAM model with one-cycle read latency.
// ---------------------------------------------------------------------------
module tb_coreahblsram_sram_arbiter;

    localparam int AW  = 19;
    localparam int LIM = 8;

    logic          HCLK = 1'b0;
    logic          HRESETN = 1'b0;
    logic          ahb_write, ahb_read;
    logic [AW-1:0] ahb_addr;
    logic [39:0]   ahb_wdata;
    logic [3:0]    ahb_byteen;
    logic [39:0]   ahb_rdata;
    logic          BUSY;
    logic          sec_req, sec_write;
    logic [AW-1:0] sec_addr;
    logic [39:0]   sec_wdata;
    logic [3:0]    sec_byteen;
    logic          sec_gnt, sec_rvalid;
    logic [39:0]   sec_rdata;
    logic [3:0]    mem_wen;
    logic          mem_ren;
    logic [AW-1:0] mem_addr;
    logic [39:0]   mem_wdata;
    logic [39:0]   mem_rdata;
    logic          prot_err;

    always #5 HCLK = ~HCLK;

    coreahblsram_sram_arbiter #(
        .MEM_AWIDTH   (AW),
        .STARVE_LIMIT (LIM)
    ) dut (
        .HCLK       (HCLK),
        .HRESETN    (HRESETN),
        .ahb_write  (ahb_write),
        .ahb_read   (ahb_read),
        .ahb_addr   (ahb_addr),
        .ahb_wdata  (ahb_wdata),
        .ahb_byteen (ahb_byteen),
        .ahb_rdata  (ahb_rdata),
        .BUSY       (BUSY),
        .sec_req    (sec_req),
        .sec_write  (sec_write),
        .sec_addr   (sec_addr),
        .sec_wdata  (sec_wdata),
        .sec_byteen (sec_byteen),
        .sec_gnt    (sec_gnt),
        .sec_rvalid (sec_rvalid),
        .sec_rdata  (sec_rdata),
        .mem_wen    (mem_wen),
        .mem_ren    (mem_ren),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .prot_err   (prot_err)
    );

    // ---------------- SRAM model: 4 lanes of 10 bits, 1-cycle read -------
    logic [39:0] sram [int unsigned];
    logic [39:0] sram_q = '0;
    assign mem_rdata = sram_q;

    function automatic logic [39:0] sram_rd(input logic [AW-1:0] a);
        if (sram.exists(32'(a))) return sram[32'(a)];
        return '0;
    endfunction

    always @(posedge HCLK) begin
        logic [39:0] cur;
        if (mem_ren) sram_q <= sram_rd(mem_addr);
        if (mem_wen != 4'd0) begin
            cur = sram_rd(mem_addr);
            for (int i = 0; i < 4; i++)
                if (mem_wen[i]) cur[i*10 +: 10] = mem_wdata[i*10 +: 10];
            sram[32'(mem_addr)] = cur;
        end
    end

    // ---------------- checking ------------------------------------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ------------------------
    // m_win: 0 = normal priority, 1 = reservation announced, 2 = window owned
    int          m_win, m_wait;
    logic        m_busy, m_rd_pend, m_prot, m_gnt;
    logic [39:0] m_rd_data, m_hold, m_last_wdata;
    logic [AW-1:0] m_last_addr;

    task automatic model_reset();
        m_win = 0; m_wait = 0; m_busy = 0; m_rd_pend = 0; m_prot = 0; m_gnt = 0;
        m_rd_data = '0; m_hold = '0; m_last_wdata = '0; m_last_addr = '0;
    endtask

    // Wait for the falling edge, compare every output against the model,
    // then advance the model across the coming rising edge.
    task automatic eval();
        logic act, own, gnt, starving;
        logic [3:0] e_wen;
        logic e_ren;
        logic [AW-1:0] e_addr;
        logic [39:0] e_wd;
        @(negedge HCLK);
        act = ahb_read | ahb_write;
        own = act && (m_win != 2);
        gnt = sec_req && !own;
        e_wen = 4'd0; e_ren = 1'b0; e_addr = m_last_addr; e_wd = m_last_wdata;
        if (own) begin
            e_wen = ahb_write ? ahb_byteen : 4'd0;
            e_ren = ahb_read; e_addr = ahb_addr; e_wd = ahb_wdata;
        end else if (gnt) begin
            e_wen = sec_write ? sec_byteen : 4'd0;
            e_ren = !sec_write; e_addr = sec_addr; e_wd = sec_wdata;
        end
        check_val("sec_gnt",    64'(sec_gnt),    64'(gnt));
        check_val("mem_wen",    64'(mem_wen),    64'(e_wen));
        check_val("mem_ren",    64'(mem_ren),    64'(e_ren));
        check_val("mem_addr",   64'(mem_addr),   64'(e_addr));
        check_val("mem_wdata",  64'(mem_wdata),  64'(e_wd));
        check_val("busy",       64'(BUSY),       64'(m_busy));
        check_val("sec_rvalid", 64'(sec_rvalid), 64'(m_rd_pend));
        check_val("sec_rdata",  64'(sec_rdata),  64'(m_rd_pend ? m_rd_data : m_hold));
        check_val("prot_err",   64'(prot_err),   64'(m_prot));
        check_val("ahb_rdata",  64'(ahb_rdata),  64'(sram_q));
        // advance
        m_last_addr = e_addr; m_last_wdata = e_wd;
        if (m_rd_pend) m_hold = m_rd_data;
        m_rd_pend = gnt && !sec_write;
        if (m_rd_pend) m_rd_data = sram_rd(sec_addr);
        if (m_win == 2 && act) m_prot = 1'b1;
        starving = (m_win == 0) && sec_req && !gnt && (m_wait == LIM);
        case (m_win)
            0: m_win = starving ? 1 : 0;
            1: m_win = gnt ? 0 : 2;
            default: m_win = 0;
        endcase
        if (sec_req && !gnt) begin
            if (m_wait < LIM) m_wait++;
        end else begin
            m_wait = 0;
        end
        m_busy = (m_win != 0);
        m_gnt = gnt;
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic set_idle();
        ahb_read = 0; ahb_write = 0; ahb_addr = '0; ahb_wdata = '0; ahb_byteen = '0;
        sec_req = 0; sec_write = 0; sec_addr = '0; sec_wdata = '0; sec_byteen = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cyc, gnt_cyc, busy_after, reached;
        logic [63:0] r64;
        logic heavy, obey;

        set_idle();
        model_reset();
        sram[32'd16] = 40'h12_3456_789A;
        #3;
        check_val("rst_busy",   64'(BUSY),       64'd0);
        check_val("rst_rvalid", 64'(sec_rvalid), 64'd0);
        check_val("rst_rdata",  64'(sec_rdata),  64'd0);
        check_val("rst_prot",   64'(prot_err),   64'd0);
        check_val("rst_wen",    64'(mem_wen),    64'd0);
        check_val("rst_ren",    64'(mem_ren),    64'd0);
        check_val("rst_addr",   64'(mem_addr),   64'd0);
        check_val("rst_wdata",  64'(mem_wdata),  64'd0);
        check_val("rst_ahb_rdata", 64'(ahb_rdata), 64'(sram_q));
        repeat (2) @(negedge HCLK);
        HRESETN = 1'b1;

        // T1: idle AHB, secondary read of the preloaded word
        tick(); sec_req = 1; sec_write = 0; sec_addr = AW'(16);
        eval();
        check_val("t1_gnt", 64'(sec_gnt), 64'd1);
        tick(); set_idle();
        eval();
        check_val("t1_rvalid", 64'(sec_rvalid), 64'd1);
        check_val("t1_rdata",  64'(sec_rdata),  64'h12_3456_789A);

        // T2: AHB reads every cycle it is allowed; secondary read held
        busy_cyc = -1; gnt_cyc = -1; busy_after = -1;
        for (int n = 0; n < 30; n++) begin
            tick();
            ahb_read = !m_busy; ahb_addr = AW'(n);
            sec_req = (gnt_cyc < 0); sec_write = 0; sec_addr = AW'(3);
            eval();
            if (gnt_cyc >= 0) begin busy_after = int'(BUSY); break; end
            if (BUSY && busy_cyc < 0) busy_cyc = n;
            if (sec_gnt) gnt_cyc = n;
        end
        check_val("t2_busy_cycle", 64'(busy_cyc), 64'd9);
        check_val("t2_gnt_by_10",  64'(gnt_cyc >= 0 && gnt_cyc <= 10), 64'd1);
        check_val("t2_busy_after", 64'(busy_after), 64'd0);
        tick(); set_idle(); eval();

        // T3: AHB write and secondary write collide
        tick();
        ahb_write = 1; ahb_addr = AW'(4); ahb_byteen = 4'h3; ahb_wdata = 40'h11_2233_4455;
        sec_req = 1; sec_write = 1; sec_addr = AW'(8); sec_byteen = 4'hF; sec_wdata = 40'hAB_CDEF_0123;
        eval();
        check_val("t3_addr", 64'(mem_addr), 64'h4);
        check_val("t3_wen",  64'(mem_wen),  64'h3);
        check_val("t3_gnt",  64'(sec_gnt),  64'd0);
        tick(); ahb_write = 0; ahb_byteen = 4'h0;
        eval();
        check_val("t3_gnt_idle", 64'(sec_gnt),  64'd1);
        check_val("t3_addr_sec", 64'(mem_addr), 64'h8);
        tick(); set_idle(); eval();

        // T4: AHB ignores BUSY and writes inside the reserved window
        gnt_cyc = -1;
        for (int n = 0; n < 30; n++) begin
            tick();
            ahb_read = 0; ahb_write = 0; ahb_byteen = 4'h0;
            if (gnt_cyc < 0) begin
                if (m_win == 2) begin
                    ahb_write = 1; ahb_addr = AW'(4); ahb_byteen = 4'hF;
                end else begin
                    ahb_read = 1; ahb_addr = AW'(n);
                end
            end
            sec_req = (gnt_cyc < 0); sec_write = 1; sec_addr = AW'(9);
            sec_byteen = 4'h5; sec_wdata = 40'h55_5555_5555;
            eval();
            if (gnt_cyc < 0 && sec_gnt) begin
                gnt_cyc = n;
                check_val("t4_wen_sec_only", 64'(mem_wen), 64'h5);
            end else if (gnt_cyc >= 0 && n == gnt_cyc + 1) begin
                check_val("t4_prot_set", 64'(prot_err), 64'd1);
            end else if (gnt_cyc >= 0 && n == gnt_cyc + 3) begin
                check_val("t4_prot_sticky", 64'(prot_err), 64'd1);
                break;
            end
        end
        check_val("t4_gnt_cycle", 64'(gnt_cyc), 64'd10);

        // T5: reset pulsed while the window is held
        reached = 0;
        for (int n = 0; n < 30; n++) begin
            tick();
            if (m_win == 2) begin
                set_idle();
                check_val("t5_busy_pre", 64'(BUSY), 64'd1);
                #1 HRESETN = 1'b0;
                #1;
                check_val("t5_busy_rst",   64'(BUSY),       64'd0);
                check_val("t5_rvalid_rst", 64'(sec_rvalid), 64'd0);
                check_val("t5_prot_rst",   64'(prot_err),   64'd0);
                model_reset();
                #1 HRESETN = 1'b1;
                eval();
                reached = 1;
                break;
            end
            ahb_read = 1; ahb_addr = AW'(n);
            sec_req = 1; sec_write = 0; sec_addr = AW'(2);
            eval();
        end
        check_val("t5_reached_sec", 64'(reached), 64'd1);
        tick(); sec_req = 1; sec_write = 0; sec_addr = AW'(16);
        eval();
        check_val("t5_pri_gnt",  64'(sec_gnt), 64'd1);
        check_val("t5_pri_busy", 64'(BUSY),    64'd0);
        tick(); set_idle(); eval();

        // Randomized traffic
        heavy = 0; obey = 1;
        for (int n = 0; n < 1500; n++) begin
            if (n % 100 == 0) begin
                heavy = ((n / 100) % 2) == 1;
                obey  = ((n / 100) % 3) != 2;
            end
            tick();
            if (!sec_req || m_gnt) begin
                sec_req = ($urandom_range(2, 0) == 0);
                sec_write = 1'($urandom());
                sec_addr = AW'($urandom_range(15, 0));
                sec_byteen = 4'($urandom());
                r64 = {$urandom(), $urandom()};
                sec_wdata = r64[39:0];
            end
            ahb_read = 0; ahb_write = 0;
            if ((heavy ? ($urandom_range(9, 0) < 9) : ($urandom_range(9, 0) < 3)) && !(obey && m_busy)) begin
                case ($urandom_range(2, 0))
                    0: ahb_read = 1;
                    1: ahb_write = 1;
                    default: begin ahb_read = 1; ahb_write = 1; end
                endcase
            end
            ahb_addr = AW'($urandom_range(15, 0));
            ahb_byteen = 4'($urandom());
            r64 = {$urandom(), $urandom()};
            ahb_wdata = r64[39:0];
            eval();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
